// File: rtl/mod12_count_monitor.sv
// In-line checker for a mod-12 up/down counter: shadows the counter, flags divergence,
// counts errors and wrap events. Optional sticky-failure mode under MON_STICKY_ERR_EN.
module mod12_count_monitor #(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              up_down,
  input  logic [3:0]        Din,
  input  logic [3:0]        count,
  output logic [3:0]        exp_count,
  output logic              mismatch,
  output logic              illegal_val,
  output logic              illegal_load,
  output logic              wrap_up,
  output logic              wrap_dn,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
`ifdef MON_STICKY_ERR_EN
  ,
  output logic              fail_flag,
  output logic [3:0]        fail_exp,
  output logic [3:0]        fail_obs
`endif
);

  localparam logic [3:0] MAX_VAL = 4'd11;

`ifdef MON_STICKY_ERR_EN
  typedef enum logic {CHECK, FAIL} state_e;
`else
  typedef enum logic {CHECK} state_e;
`endif

  state_e              state_q, state_d;
  logic [3:0]          exp_q, exp_d;
  logic                mis_q, mis_d;
  logic                ival_q, ival_d;
  logic                iload_q, iload_d;
  logic                wu_q, wu_d;
  logic                wd_q, wd_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [WRAP_W-1:0]   wrap_q, wrap_d;
  logic [3:0]          base;
  logic                adv;
`ifdef MON_STICKY_ERR_EN
  logic [3:0]          fexp_q, fexp_d;
  logic [3:0]          fobs_q, fobs_d;
`endif

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = err_q;
    wrap_d  = wrap_q;
    base    = exp_q;
    adv     = 1'b1;
`ifdef MON_STICKY_ERR_EN
    fexp_d  = fexp_q;
    fobs_d  = fobs_q;
`endif
    ival_d  = (count > MAX_VAL);
    iload_d = load && (Din > MAX_VAL);
    mis_d   = (count != exp_q);
    wu_d    = 1'b0;
    wd_d    = 1'b0;

    if (mis_d && (err_q != '1)) err_d = err_q + 1'b1;

    case (state_q)
      CHECK: begin
`ifdef MON_STICKY_ERR_EN
        if (mis_d) begin
          state_d = FAIL;
          fexp_d  = exp_q;
          fobs_d  = count;
          adv     = 1'b0;
        end
`else
        // Re-anchor on the observed value so a single glitch costs one error only.
        if (mis_d) base = ival_d ? 4'd0 : count;
`endif
      end
      default: adv = 1'b0;
    endcase

    if (adv) begin
      if (load) begin
        exp_d = iload_d ? 4'd0 : Din;
      end else if (up_down) begin
        wu_d  = (base == MAX_VAL);
        exp_d = wu_d ? 4'd0 : base + 4'd1;
      end else begin
        wd_d  = (base == 4'd0);
        exp_d = wd_d ? MAX_VAL : base - 4'd1;
      end
    end

    if ((wu_d || wd_d) && (wrap_q != '1)) wrap_d = wrap_q + 1'b1;
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and masks every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHECK;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      ival_q  <= 1'b0;
      iload_q <= 1'b0;
      wu_q    <= 1'b0;
      wd_q    <= 1'b0;
      err_q   <= '0;
      wrap_q  <= '0;
`ifdef MON_STICKY_ERR_EN
      fexp_q  <= '0;
      fobs_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q <= state_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      ival_q  <= ival_d;
      iload_q <= iload_d;
      wu_q    <= wu_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
`ifdef MON_STICKY_ERR_EN
      fexp_q  <= fexp_d;
      fobs_q  <= fobs_d;
`endif
    end
  end

  assign exp_count    = exp_q;
  assign mismatch     = mis_q;
  assign illegal_val  = ival_q;
  assign illegal_load = iload_q;
  assign wrap_up      = wu_q;
  assign wrap_dn      = wd_q;
  assign err_cnt      = err_q;
  assign wrap_cnt     = wrap_q;
`ifdef MON_STICKY_ERR_EN
  assign fail_flag    = (state_q == FAIL);
  assign fail_exp     = fexp_q;
  assign fail_obs     = fobs_q;
`endif

endmodule
